// File: rtl/imm_ext_pipe.sv
// Immediate extender (sign / zero / sign-shift-1 / load-upper) behind a one-cycle
// output register with a one-entry skid buffer. Define IMM_EXT_LUI_EN to enable mode 3.
module imm_ext_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int EXT_W = OUT_W - IN_W;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             accept;
  logic             out_free;

  always_comb begin
    sext     = {{EXT_W{in_data[IN_W-1]}}, in_data};
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      2'd0:    ext_data = sext;
      2'd1:    ext_data = {{EXT_W{1'b0}}, in_data};
      2'd2:    ext_data = {sext[OUT_W-2:0], 1'b0};
      default: begin
`ifdef IMM_EXT_LUI_EN
        ext_data = {in_data, {EXT_W{1'b0}}};
`else
        ext_err  = 1'b1;
`endif
      end
    endcase
  end

  // Handshake: a beat moves on a port when its valid and ready are both high at
  // a rising edge. in_ready depends only on skid occupancy (and reset), never on
  // out_ready, so the upstream path is cut by the skid register.
  assign in_ready = rst_n & ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    if (out_free) begin
      // Skid entry is older than any new beat, so it always wins the output slot.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_data;
        out_err_d   = ext_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_err_d   = ext_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe (IN_W=8, OUT_W=16): extension modes, stall/skid,
// back-to-back streaming and reset during a full stall.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  int          checks   = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_e;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left #1 after a rising edge.
  task automatic single(input logic [7:0] d, input logic [1:0] m,
                        input logic [15:0] ed, input logic ee, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_err"}, out_err, ee);
    step();
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 0);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 2'd0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", in_ready, 0);
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 16'h0000);
    check("rst_err", out_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", in_ready, 1);
    check("rel_vld", out_valid, 0);
    out_ready = 1'b1;
    step();

    single(8'h80, 2'd0, 16'hFF80, 1'b0, "m0_80");
    single(8'h80, 2'd1, 16'h0080, 1'b0, "m1_80");
    single(8'hC0, 2'd2, 16'hFF80, 1'b0, "m2_c0");
    single(8'h7F, 2'd2, 16'h00FE, 1'b0, "m2_7f");
`ifdef IMM_EXT_LUI_EN
    single(8'h12, 2'd3, 16'h1200, 1'b0, "m3_12");
`else
    single(8'h12, 2'd3, 16'h0000, 1'b1, "m3_12");
`endif
    single(8'h7F, 2'd0, 16'h007F, 1'b0, "m0_7f");
    single(8'hFF, 2'd1, 16'h00FF, 1'b0, "m1_ff");
    single(8'h01, 2'd2, 16'h0002, 1'b0, "m2_01");
    single(8'hFF, 2'd2, 16'hFFFE, 1'b0, "m2_ff");

    // Stall: two beats fill output and skid, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_mode   = 2'd1;
    @(negedge clk);
    check("stall_rdy0", in_ready, 1);
    step();
    in_data = 8'h02;
    @(negedge clk);
    check("stall_vld", out_valid, 1);
    check("stall_d1", out_data, 16'h0001);
    check("stall_rdy1", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_full_rdy", in_ready, 0);
    check("stall_hold", out_data, 16'h0001);
    step();
    @(negedge clk);
    check("stall_hold2", out_data, 16'h0001);
    check("stall_full_rdy2", in_ready, 0);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("stall_vld2", out_valid, 1);
    check("stall_d2", out_data, 16'h0002);
    check("stall_rdy_back", in_ready, 1);
    step();
    @(negedge clk);
    check("stall_drain", out_valid, 0);
    step();

    // Back-to-back streaming with out_ready held high.
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 16);
      in_data  = 8'h70 + 8'(c * 8);
      in_mode  = 2'd1;
      @(negedge clk);
      check("strm_ovld", out_valid, (c >= 1 && c <= 16));
      if (out_valid) begin
        check("strm_q_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("strm_data", {out_err, out_data}, exp_e);
        end
      end
      if (in_valid) begin
        check("strm_rdy", in_ready, 1);
        if (in_ready) exp_q.push_back({1'b0, 8'h00, in_data});
      end
      step();
    end
    check("strm_left", exp_q.size(), 0);
    in_valid = 1'b0;

    // Reset while both registers are full and stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    in_mode   = 2'd1;
    step();
    in_data = 8'hBB;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("rs_full_rdy", in_ready, 0);
    check("rs_full_data", out_data, 16'h00AA);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #1 check("rs_rdy_low", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rs_vld", out_valid, 0);
    check("rs_data", out_data, 16'h0000);
    check("rs_err", out_err, 0);
    check("rs_rdy", in_ready, 1);
    step();
    @(negedge clk);
    check("rs_nostale", out_valid, 0);
    step();
    single(8'h05, 2'd1, 16'h0005, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, meaning immediate input width in bits (legal range 1..OUT_W-1).
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning extended output width in bits (legal range IN_W+1..64).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream beat is present.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the beat this cycle.
REQ-007 The block SHALL have port in_data, input, IN_W, the raw immediate.
REQ-008 The block SHALL have port in_mode, input, 2, the extension mode (0 sign, 1 zero, 2 sign-shift-1, 3 load-upper).
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is present.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 The block SHALL have port out_data, output, OUT_W, the extended result.
REQ-012 The block SHALL have port out_err, output, 1, flagging a result produced from an unsupported mode, qualified by out_valid.

Function
REQ-013 Mode 0 SHALL produce out_data = in_data with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
REQ-014 Mode 1 SHALL produce out_data = in_data with bits OUT_W-1..IN_W zero.
REQ-015 Mode 2 SHALL produce the mode-0 result shifted left by one bit, bit 0 zero, MSB discarded (truncated to OUT_W).
REQ-016 Mode 3 SHALL be governed by REQ-030/REQ-031.
REQ-017 A beat SHALL transfer on the input when in_valid and in_ready are both high in a cycle, and on the output when out_valid and out_ready are both high.
REQ-018 Latency SHALL be exactly one cycle: a beat accepted at edge N, with the output register empty or draining, appears with out_valid high after edge N.
REQ-019 The block SHALL hold one output register plus a one-entry skid register, sustaining one beat per cycle when out_ready stays high.
REQ-020 in_ready SHALL be high exactly when the skid register is empty; it SHALL not depend combinationally on out_ready.
REQ-021 A beat accepted while out_valid is high and out_ready is low SHALL be stored in the skid register, and in_ready SHALL fall on the following cycle.
REQ-022 When the output transfers and the skid register is full, the skid entry SHALL move to the output register on the same edge and in_ready SHALL rise on the next cycle.
REQ-023 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-024 While out_valid is high and out_ready is low, out_data and out_err SHALL remain stable.
REQ-025 When the output is empty and there is no input, out_valid SHALL go low after the edge on which the last beat transferred.
REQ-026 When an output transfer and an input acceptance occur on the same edge with the skid register empty, the new beat SHALL load directly into the output register.

Reset
REQ-027 While rst_n is low at a rising edge, out_valid, out_err and the skid-valid flag SHALL clear to 0, out_data and the skid data SHALL clear to all zeros, and any in-flight beats SHALL be discarded.
REQ-028 in_ready SHALL be 0 while rst_n is low and SHALL be 1 in the first cycle after rst_n goes high.
REQ-029 Reset asserted during a stall SHALL take priority over any transfer on the same edge.

Configuration
REQ-030 With macro IMM_EXT_LUI_EN defined, mode 3 SHALL place in_data in bits OUT_W-1..OUT_W-IN_W with the lower bits zero, and out_err SHALL be 0.
REQ-031 Without IMM_EXT_LUI_EN, mode 3 SHALL produce out_data all zeros with out_err 1, with handshake timing unchanged; modes 0-2 set out_err 0 in both builds.

Verification
REQ-032 With IN_W=8 and OUT_W=16, driving in_data 0x80 in mode 0 and then mode 1 with out_ready=1 SHALL give out_data 0xFF80 then 0x0080, each one cycle after acceptance.
REQ-033 Driving in_data 0xC0 in mode 2 SHALL give 0xFF80, and 0x7F in mode 2 SHALL give 0x00FE.
REQ-034 Driving in_data 0x12 in mode 3 SHALL give 0x1200 with out_err 0 when IMM_EXT_LUI_EN is defined, and 0x0000 with out_err 1 when it is not.
REQ-035 With out_ready held low, sending beats 0x01 and 0x02 (mode 1) SHALL make in_ready fall after the second; releasing out_ready SHALL give 0x0001 then 0x0002 on consecutive cycles, with in_ready high again.
REQ-036 Streaming 16 back-to-back beats with out_ready=1 SHALL give 16 outputs on consecutive cycles with in_ready constantly 1.
REQ-037 Asserting rst_n low for one edge while both registers are full and stalled SHALL give out_valid 0 and out_data 0x0000 next cycle and in_ready 1 after release, and no stale beat SHALL emerge.
